// File: rtl/vram_pkg.sv
// Shared types and constants for the vector-RAM drain arbiter.
//   arb_state_t        : arbitration FSM states (RUN, FLUSH, START)
//   VRAM_ADDR_W        : width of the VRAM-relative address
//   DEFAULT_VRAM_BASE  : first CPU address mapped onto vector RAM
//   DEFAULT_VRAM_LIMIT : last CPU address mapped onto vector RAM
package vram_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        START = 2'd2
    } arb_state_t;

    localparam int          VRAM_ADDR_W        = 13;
    localparam logic [15:0] DEFAULT_VRAM_BASE  = 16'h2000;
    localparam logic [15:0] DEFAULT_VRAM_LIMIT = 16'h3FFF;

endpackage

// File: rtl/vram_drain_arbiter_if.sv
// Bus bundle between the CPU store queue, the vector generator and the
// single vector-RAM port.
//   queue side : q_data, q_addr, q_valid, q_empty in; q_pop out
//   VG side    : vg_req, vg_addr, vg_go in; vg_gnt, vg_rdata, vg_rvalid, vg_start out
//   RAM port   : bram_dout in; bram_addr, bram_din, bram_we out
// The slave modport is the arbiter's view, master is the environment's view.
interface vram_drain_arbiter_if;
    import vram_pkg::*;

    logic [7:0]             q_data;
    logic [15:0]            q_addr;
    logic                   q_valid;
    logic                   q_empty;
    logic                   q_pop;
    logic                   vg_req;
    logic [VRAM_ADDR_W-1:0] vg_addr;
    logic                   vg_gnt;
    logic [7:0]             vg_rdata;
    logic                   vg_rvalid;
    logic                   vg_go;
    logic                   vg_start;
    logic [VRAM_ADDR_W-1:0] bram_addr;
    logic [7:0]             bram_din;
    logic                   bram_we;
    logic [7:0]             bram_dout;

    modport slave (
        input  q_data, q_addr, q_valid, q_empty, vg_req, vg_addr, vg_go, bram_dout,
        output q_pop, vg_gnt, vg_rdata, vg_rvalid, vg_start, bram_addr, bram_din, bram_we
    );

    modport master (
        output q_data, q_addr, q_valid, q_empty, vg_req, vg_addr, vg_go, bram_dout,
        input  q_pop, vg_gnt, vg_rdata, vg_rvalid, vg_start, bram_addr, bram_din, bram_we
    );

endinterface

// File: rtl/vram_drain_arbiter_sat_counter.sv
// Saturating up-counter.
//   clk, rst_n : clock, asynchronous active-low reset (clears to 0)
//   inc        : increment request, ignored once the count is all-ones
//   count      : current count
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vram_drain_arbiter.sv
// Drain end of the CPU store queue for vector RAM. Commits queued CPU writes
// to the single RAM port, shares that port with VG reads (bounded starvation
// both ways) and flushes all pending writes before pulsing vg_start.
//   clk, rst_n : clock, asynchronous active-low reset
//   arb_if     : queue / VG / RAM-port bundle (slave view)
//   drop_cnt   : saturating count of popped entries outside the VRAM window
//
// state | meaning
// RUN   | normal arbitration between VG reads and queue drains
// FLUSH | go seen: drain until the queue is observed empty, no VG grants
// START | one-cycle vg_start pulse, then back to RUN
module vram_drain_arbiter
    import vram_pkg::*;
#(
    parameter int          MAX_VG_STREAK = 4,
    parameter logic [15:0] VRAM_BASE     = DEFAULT_VRAM_BASE,
    parameter logic [15:0] VRAM_LIMIT    = DEFAULT_VRAM_LIMIT,
    parameter int          CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vram_drain_arbiter_if.slave   arb_if,
    output logic [CNT_W-1:0]      drop_cnt
);

    localparam int                STREAK_W   = $clog2(MAX_VG_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VG_STREAK);

    arb_state_t             state_q, state_d;
    logic [STREAK_W-1:0]    streak_q, streak_d;
    logic                   go_q;
    logic                   vg_rvalid_q;
    logic [7:0]             rdata_hold_q;
    logic                   vg_start_q;

    logic                   pop_d;
    logic                   gnt_d;
    logic                   go_edge;
    logic                   in_win;
    logic                   drop_inc;
    logic [VRAM_ADDR_W-1:0] q_off;

    assign go_edge = arb_if.vg_go & ~go_q;
    assign in_win  = (arb_if.q_addr >= VRAM_BASE) && (arb_if.q_addr <= VRAM_LIMIT);
    assign q_off   = VRAM_ADDR_W'(arb_if.q_addr - VRAM_BASE);

    always_comb begin
        pop_d    = 1'b0;
        gnt_d    = 1'b0;
        state_d  = state_q;
        streak_d = streak_q;
        case (state_q)
            RUN: begin
                // The streak only counts VG wins against a waiting queue;
                // with nothing to drain the VG may be granted indefinitely.
                if (arb_if.vg_req && (streak_q < STREAK_MAX)) begin
                    gnt_d    = 1'b1;
                    streak_d = arb_if.q_empty ? '0 : streak_q + STREAK_W'(1);
                end else if (!arb_if.q_empty) begin
                    pop_d    = 1'b1;
                    streak_d = '0;
                end else begin
                    streak_d = '0;
                end
                if (go_edge) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Exit only on an observed empty queue, so refills keep draining.
                if (!arb_if.q_empty) begin
                    pop_d = 1'b1;
                end else begin
                    state_d = START;
                end
            end
            START: begin
                state_d  = RUN;
                streak_d = '0;
            end
            default: begin
                state_d  = RUN;
                streak_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            streak_q     <= '0;
            go_q         <= 1'b0;
            vg_rvalid_q  <= 1'b0;
            rdata_hold_q <= 8'h00;
            vg_start_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            go_q        <= arb_if.vg_go;
            vg_rvalid_q <= gnt_d;
            vg_start_q  <= (state_d == START);
            if (vg_rvalid_q) begin
                rdata_hold_q <= arb_if.bram_dout;
            end
        end
    end

    // Combinational handshakes are gated by rst_n so they drop the instant
    // reset asserts, not at the next edge.
    assign arb_if.q_pop     = pop_d & rst_n;
    assign arb_if.vg_gnt    = gnt_d & rst_n;
    assign arb_if.bram_we   = pop_d & arb_if.q_valid & in_win & rst_n;
    assign arb_if.bram_addr = gnt_d ? arb_if.vg_addr : q_off;
    assign arb_if.bram_din  = arb_if.q_data;

    // RAM output is already registered, so the return cycle passes it straight
    // through and the hold register keeps it afterwards.
    assign arb_if.vg_rvalid = vg_rvalid_q;
    assign arb_if.vg_rdata  = vg_rvalid_q ? arb_if.bram_dout : rdata_hold_q;
    assign arb_if.vg_start  = vg_start_q;

    assign drop_inc = pop_d & arb_if.q_valid & ~in_win;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (drop_inc),
        .count (drop_cnt)
    );

endmodule
